// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the IF PC register controls, runs the
// req/ack handshake to instruction memory and holds one word for decode.
module fetch_ctrl #(
  parameter int          ADDR_W  = 16,
  parameter int          DATA_W  = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              hlt,
  output logic              useAlt,
  output logic [ADDR_W-1:0] altAddress,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memData,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectAddr,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instrValid,
  output logic              halted
);

  // state  | meaning
  // IDLE   | one settling cycle after reset, PC frozen
  // FETCH  | request to pc outstanding; ack loads instr and advances PC
  // WAIT   | loaded word blocked by stall; no new request until it drains
  // SQUASH | old request still outstanding after a redirect; its data is dropped
  // HALTED | HALT opcode fetched; only rst leaves this state
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SQUASH,
    HALTED
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              redir_en;
  logic              consume;
  logic              is_halt;

  always_comb begin
    redir_en   = redirect && ((state == FETCH) || (state == WAIT) || (state == SQUASH));
    consume    = instrValid && !stall;
    is_halt    = (memData[DATA_W-1 -: 4] == HALT_OP);
    useAlt     = redir_en;
    altAddress = redir_en ? redirectAddr : '0;
    hlt        = !(redir_en || ((state == FETCH) && memAck));
    // Gated by rst so an outstanding request is dropped in the reset cycle itself
    memReq     = !rst && ((state == FETCH) || (state == SQUASH));
    memAddr    = (state == FETCH) ? pc : addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      instr      <= '0;
      instrValid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      if (consume) instrValid <= 1'b0;

      unique case (state)
        IDLE: state <= FETCH;

        FETCH: begin
          addr_q <= pc;
          if (redirect) begin
            instrValid <= 1'b0;
            state      <= memAck ? FETCH : SQUASH;
          end else if (memAck) begin
            instr      <= memData;
            instrValid <= 1'b1;
            if (is_halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else if (stall) begin
              state <= WAIT;
            end else begin
              state <= FETCH;
            end
          end
        end

        WAIT: begin
          if (redirect) begin
            instrValid <= 1'b0;
            state      <= FETCH;
          end else if (consume) begin
            state <= FETCH;
          end
        end

        SQUASH: begin
          if (redirect) instrValid <= 1'b0;
          if (memAck) state <= FETCH;
        end

        HALTED: halted <= 1'b1;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural IF PC register; every
// expected value below is worked out by hand from the intended behaviour.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc;
  logic        hlt, useAlt, memReq, instrValid, halted;
  logic [15:0] altAddress, memAddr, instr;
  logic        memAck = 1'b0;
  logic [15:0] memData = 16'h0;
  logic        redirect = 1'b0;
  logic [15:0] redirectAddr = 16'h0;
  logic        stall = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_ctrl #(.ADDR_W(16), .DATA_W(16), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .pc(pc), .hlt(hlt), .useAlt(useAlt),
    .altAddress(altAddress), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memData(memData), .redirect(redirect),
    .redirectAddr(redirectAddr), .stall(stall), .instr(instr),
    .instrValid(instrValid), .halted(halted)
  );

  always #5 clk = ~clk;

  // IF PC register, reset from the same source as the controller
  always @(posedge clk) begin
    if (rst)         pc <= 16'h0;
    else if (useAlt) pc <= altAddress;
    else if (!hlt)   pc <= pc + 16'h1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ack, input logic [15:0] data, input logic red,
                     input logic [15:0] raddr, input logic st);
    @(negedge clk);
    memAck = ack; memData = data; redirect = red; redirectAddr = raddr; stall = st;
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    // reset state (IDLE)
    chk1("rst_memReq", memReq, 1'b0);
    chk1("rst_hlt", hlt, 1'b1);
    chk1("rst_useAlt", useAlt, 1'b0);
    chk1("rst_valid", instrValid, 1'b0);
    chk16("rst_instr", instr, 16'h0);
    chk1("rst_halted", halted, 1'b0);
    chk16("rst_pc", pc, 16'h0);

    // back-to-back fetch
    cyc(1, 16'h0100, 0, 0, 0);
    chk1("b2b0_req", memReq, 1'b1); chk16("b2b0_addr", memAddr, 16'h0000); chk1("b2b0_hlt", hlt, 1'b0);
    cyc(1, 16'h0101, 0, 0, 0);
    chk16("b2b1_instr", instr, 16'h0100); chk1("b2b1_valid", instrValid, 1'b1);
    chk16("b2b1_addr", memAddr, 16'h0001); chk1("b2b1_hlt", hlt, 1'b0);
    cyc(1, 16'h0102, 0, 0, 0);
    chk16("b2b2_instr", instr, 16'h0101); chk16("b2b2_addr", memAddr, 16'h0002); chk1("b2b2_hlt", hlt, 1'b0);

    // variable latency: three request cycles without ack, ack on the fourth
    cyc(0, 16'h0000, 0, 0, 0);
    chk16("lat0_instr", instr, 16'h0102); chk16("lat0_pc", pc, 16'h0003);
    chk1("lat0_req", memReq, 1'b1); chk16("lat0_addr", memAddr, 16'h0003); chk1("lat0_hlt", hlt, 1'b1);
    cyc(0, 16'h0000, 0, 0, 0);
    chk1("lat1_valid", instrValid, 1'b0); chk16("lat1_addr", memAddr, 16'h0003);
    chk1("lat1_hlt", hlt, 1'b1); chk16("lat1_pc", pc, 16'h0003);
    cyc(0, 16'h0000, 0, 0, 0);
    chk16("lat2_addr", memAddr, 16'h0003); chk1("lat2_hlt", hlt, 1'b1); chk16("lat2_pc", pc, 16'h0003);
    cyc(1, 16'h0103, 0, 0, 0);
    chk16("lat3_addr", memAddr, 16'h0003); chk1("lat3_hlt", hlt, 1'b0);

    // stall: drain 0x0103, then load 0x0104 with stall held four cycles
    cyc(0, 16'h0000, 0, 0, 0);
    chk16("st_pre_instr", instr, 16'h0103); chk16("st_pre_pc", pc, 16'h0004);
    cyc(1, 16'h0104, 0, 0, 1);
    chk16("st_ack_addr", memAddr, 16'h0004); chk1("st_ack_hlt", hlt, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0000, 0, 0, 1);
      chk1("st_wait_req", memReq, 1'b0); chk1("st_wait_hlt", hlt, 1'b1);
      chk16("st_wait_instr", instr, 16'h0104); chk1("st_wait_valid", instrValid, 1'b1);
      chk16("st_wait_pc", pc, 16'h0005);
    end
    cyc(0, 16'h0000, 0, 0, 0);
    chk1("st_drain_req", memReq, 1'b0); chk1("st_drain_valid", instrValid, 1'b1);
    cyc(1, 16'h0105, 0, 0, 0);
    chk1("st_res_req", memReq, 1'b1); chk16("st_res_addr", memAddr, 16'h0005);
    chk1("st_res_valid", instrValid, 1'b0);

    // redirect with request to 6 outstanding; redirect beats stall
    cyc(0, 16'h0000, 1, 16'h0040, 1);
    chk16("rd_instr", instr, 16'h0105); chk1("rd_useAlt", useAlt, 1'b1); chk1("rd_hlt", hlt, 1'b0);
    chk16("rd_alt", altAddress, 16'h0040); chk16("rd_addr", memAddr, 16'h0006);
    cyc(0, 16'h0000, 0, 16'h0040, 0);
    chk1("sq_useAlt", useAlt, 1'b0); chk16("sq_alt", altAddress, 16'h0000);
    chk1("sq_valid", instrValid, 1'b0); chk1("sq_req", memReq, 1'b1);
    chk16("sq_addr", memAddr, 16'h0006); chk1("sq_hlt", hlt, 1'b1); chk16("sq_pc", pc, 16'h0040);
    cyc(1, 16'hBEEF, 0, 0, 0);
    chk16("sq_ack_addr", memAddr, 16'h0006); chk1("sq_ack_hlt", hlt, 1'b1);
    cyc(1, 16'h0140, 0, 0, 0);
    chk16("sq_done_instr", instr, 16'h0105); chk1("sq_done_valid", instrValid, 1'b0);
    chk16("sq_done_addr", memAddr, 16'h0040); chk1("sq_done_hlt", hlt, 1'b0);

    // redirect and ack of a HALT word in the same cycle
    cyc(1, 16'hF000, 1, 16'h0200, 0);
    chk16("rh_instr", instr, 16'h0140); chk16("rh_addr", memAddr, 16'h0041);
    chk1("rh_useAlt", useAlt, 1'b1); chk1("rh_hlt", hlt, 1'b0);
    cyc(1, 16'h0300, 0, 0, 0);
    chk1("rh_halted", halted, 1'b0); chk1("rh_valid", instrValid, 1'b0);
    chk16("rh_instr2", instr, 16'h0140); chk16("rh_pc", pc, 16'h0200);
    chk1("rh_req", memReq, 1'b1); chk16("rh_addr2", memAddr, 16'h0200);

    // HALT word delivered, then fetch stops
    cyc(1, 16'hF123, 0, 0, 0);
    chk16("h_prev_instr", instr, 16'h0300); chk1("h_ack_hlt", hlt, 1'b0);
    cyc(0, 16'h0000, 0, 0, 1);
    chk1("h_halted", halted, 1'b1); chk16("h_instr", instr, 16'hF123); chk1("h_valid", instrValid, 1'b1);
    chk1("h_req", memReq, 1'b0); chk1("h_hlt", hlt, 1'b1); chk16("h_pc", pc, 16'h0202);
    cyc(0, 16'h0000, 1, 16'h0999, 0);
    chk1("h_red_useAlt", useAlt, 1'b0); chk1("h_red_hlt", hlt, 1'b1);
    chk16("h_red_alt", altAddress, 16'h0000); chk1("h_red_valid", instrValid, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(logic'(i[0]), 16'h0F0F, 0, 0, 0);
      chk1("hl_halted", halted, 1'b1); chk1("hl_req", memReq, 1'b0); chk1("hl_hlt", hlt, 1'b1);
      chk1("hl_valid", instrValid, 1'b0); chk16("hl_pc", pc, 16'h0202);
    end

    // reset out of HALTED; late ack and redirect in IDLE are ignored
    @(negedge clk);
    rst = 1'b1; memAck = 1'b0; redirect = 1'b0;
    @(negedge clk);
    rst = 1'b0; memAck = 1'b1; memData = 16'hF111; redirect = 1'b1; redirectAddr = 16'h0077;
    #1;
    chk1("ri_req", memReq, 1'b0); chk1("ri_hlt", hlt, 1'b1); chk1("ri_useAlt", useAlt, 1'b0);
    chk16("ri_alt", altAddress, 16'h0000); chk1("ri_halted", halted, 1'b0);
    chk16("ri_instr", instr, 16'h0000); chk16("ri_pc", pc, 16'h0000);
    cyc(0, 16'h0000, 0, 0, 0);
    chk1("ri_late_valid", instrValid, 1'b0); chk1("ri_req2", memReq, 1'b1);
    chk16("ri_addr", memAddr, 16'h0000); chk16("ri_pc2", pc, 16'h0000);
    cyc(1, 16'h0100, 0, 0, 0);
    chk1("ri_ack_hlt", hlt, 1'b0);

    // reset with a request outstanding drops memReq at once
    @(negedge clk);
    rst = 1'b1; memAck = 1'b0;
    #1;
    chk16("rm_instr", instr, 16'h0100); chk1("rm_req", memReq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rm_valid", instrValid, 1'b0); chk16("rm_instr2", instr, 16'h0000); chk16("rm_pc", pc, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences the instruction-fetch PC register (hlt, useAlt, altAddress, pc) against a variable-latency instruction memory with a req/ack handshake. It delivers fetched words to decode through a one-entry output register with backpressure. It also applies branch/jump redirects, squashes in-flight fetches, and stops fetch permanently on a HALT opcode. The block sits between the IF PC register, instruction memory and the decode stage.

Parameters:
ADDR_W, 16, PC / memory address width
DATA_W, 16, instruction width
HALT_OP, 4'hF, opcode value (instr[DATA_W-1:DATA_W-4]) that halts fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
pc  in  ADDR_W  current PC from the IF PC register
hlt  out  1  freeze PC this cycle
useAlt  out  1  load altAddress into PC this cycle
altAddress  out  ADDR_W  redirect target for the PC register
memReq  out  1  instruction memory request
memAddr  out  ADDR_W  request address; stable while memReq=1 and memAck=0
memAck  in  1  one-cycle data-valid strobe for the outstanding request
memData  in  DATA_W  fetched word, valid when memAck=1
redirect  in  1  one-cycle branch/jump-taken pulse from the execute stage
redirectAddr  in  ADDR_W  redirect target
stall  in  1  decode cannot accept instr this cycle
instr  out  DATA_W  instruction to decode (registered)
instrValid  out  1  instr holds a valid, unconsumed word
halted  out  1  HALT fetched; fetch stopped

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; instr=0; instrValid=0; halted=0; address latch=0.
  - Combinational outputs while in IDLE: memReq=0, hlt=1, useAlt=0.
  - The PC register's reset is driven from the same source, so pc=0 after reset.
- Consume: the output word is consumed in any cycle with instrValid=1 and stall=0. A consumed word clears instrValid at the edge unless a new word is loaded at the same edge.
- States:
  - IDLE: goes to FETCH after one cycle.
  - FETCH:
    - Drives memReq=1 and memAddr=pc; the address latch captures pc every cycle.
    - On memAck (no redirect): instr<=memData, instrValid<=1, hlt=0 for that cycle (PC advances by 1).
    - Next state after an ack: HALTED if opcode==HALT_OP; else WAIT if stall=1 (the loaded word cannot drain next cycle); else FETCH.
    - Back-to-back fetches are allowed: with memAck every cycle and stall=0, one instruction per cycle.
    - With no ack, hlt=1.
  - WAIT: memReq=0, hlt=1; returns to FETCH in the cycle after instrValid=1 and stall=0 is seen.
  - SQUASH:
    - Drives memReq=1 and memAddr=address latch (the old address); hlt=1.
    - On memAck the data is discarded, nothing is loaded, and the state returns to FETCH.
  - HALTED: memReq=0, hlt=1, halted=1. The last word (the HALT itself) still drains to decode normally. Exited only by rst.
- Redirect (any state except HALTED and IDLE):
  - Same cycle: useAlt=1, hlt=0, altAddress=redirectAddr; PC loads the target at the edge.
  - Flush: instrValid<=0; instr is not updated.
  - In FETCH with memAck=0: go to SQUASH (the request remains outstanding to the old address).
  - In FETCH with memAck=1: data discarded, HALT detection suppressed, stay in FETCH.
  - In SQUASH: stay in SQUASH if memAck=0, else go to FETCH.
  - In WAIT: go to FETCH.
  - Redirect outranks memAck, HALT detection and stall.
- Ignored inputs: redirect in HALTED and in IDLE is ignored (useAlt=0).
- altAddress is redirectAddr when useAlt=1, else 0.
- useAlt and hlt are combinational from state, memAck and redirect. Never useAlt=1 with hlt=1.
- Reset mid-operation:
  - Any outstanding request is abandoned and memReq drops immediately.
  - The memory subsystem is reset with the same rst; a late memAck arriving in IDLE is ignored.
- Address arithmetic: the PC increments modulo 2^ADDR_W, so 16'hFFFF wraps to 0. This wrap happens in the PC register; no special case here.

Test Plan:
1. Reset, memAck every cycle from cycle 1, stall=0, memory returns addr+16'h0100 → instr sequence 0x0100, 0x0101, 0x0102 on consecutive cycles; memAddr=0,1,2; hlt=0 each ack cycle.
2. Variable latency: memAck 3 cycles after req → memReq held 3 cycles with memAddr constant, hlt=1 throughout, pc steps by 1 only on the ack cycle.
3. stall=1 for 4 cycles after first ack → instr=0x0100 held with instrValid=1, memReq=0 (WAIT); stall drops → FETCH resumes at pc=1, no word lost or duplicated.
4. redirect to 16'h0040 while a req to 5 is outstanding, ack 2 cycles later with 0xBEEF → useAlt=1 for one cycle, instrValid=0, 0xBEEF never appears on instr, next memAddr=0x0040.
5. Fetch word 0xF123 (HALT_OP) → delivered on instr, then halted=1, memReq=0, hlt=1 for 20 cycles, a redirect pulse has no effect; rst → fetch restarts at 0.
6. redirect and memAck with 0xF000 in the same cycle → no halt, word discarded, pc=redirectAddr, fetch continues.
